// File: rtl/fifo_sync_flex.sv
// Synchronous single-clock show-ahead FIFO with valid/ready handshakes, flush,
// fill level and programmable almost-full/almost-empty flags; any depth >= 2.
module fifo_sync_flex #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AFULL_LVL  = FIFO_DEPTH - 1,
    parameter int unsigned AEMPTY_LVL = 1,
    parameter int unsigned LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [LW-1:0]         level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LVL);
    localparam logic [LW-1:0] LVL_AEMPT = LW'(AEMPTY_LVL);

    // Elaboration-time parameter legality
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_flex: FIFO_DEPTH must be >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > FIFO_DEPTH) begin : g_bad_afull
        $error("fifo_sync_flex: AFULL_LVL must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_LVL > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_flex: AEMPTY_LVL must be in 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  push_ready_q, push_ready_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  push_c;
    logic                  pop_c;

    assign push_c = push_valid_i & push_ready_q;
    assign pop_c  = pop_valid_q & pop_ready_i;

    // Next-state: flush wins over any handshake; flags follow the next level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        push_ready_d = (level_d != LVL_FULL);
        pop_valid_d  = (level_d != '0);
        afull_d      = (level_d >= LVL_AFULL);
        aempty_d     = (level_d <= LVL_AEMPT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            push_ready_q <= 1'b1;
            pop_valid_q  <= 1'b0;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            push_ready_q <= push_ready_d;
            pop_valid_q  <= pop_valid_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
        end
    end

    // Storage is not reset; a flushed push is discarded
    always_ff @(posedge clk) begin
        if (push_c && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign push_ready_o   = push_ready_q;
    assign pop_valid_o    = pop_valid_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign level_o        = level_q;
    assign pop_data_o     = mem_q[rd_ptr_q];

    // Occupancy implied by the pointers, to cross-check the level counter
    logic [LW:0] ptr_occ_c;
    always_comb begin
        if (wr_ptr_q >= rd_ptr_q) begin
            ptr_occ_c = (LW+1)'(wr_ptr_q) - (LW+1)'(rd_ptr_q);
        end else begin
            ptr_occ_c = (LW+1)'(wr_ptr_q) + (LW+1)'(FIFO_DEPTH) - (LW+1)'(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (level_q <= LVL_FULL);
            assert (!(push_c && level_q == LVL_FULL));
            assert (!(pop_c && level_q == '0));
            assert ((ptr_occ_c == {1'b0, level_q}) ||
                    (level_q == LVL_FULL && ptr_occ_c == '0));
        end
    end

    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_valid_o && !pop_ready_i && !flush_i) |=> $stable(pop_data_o));

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed table-driven bench for fifo_sync_flex: a depth-5 and a depth-4
// instance, plus a hand-written asynchronous mid-burst reset sequence.
module tb_fifo_sync_flex;

    logic clk;
    logic rst_n;

    logic       a_flush, a_pv, a_pr, a_prdy, a_pval, a_af, a_ae;
    logic [7:0] a_pd, a_pdat;
    logic [2:0] a_lvl;
    logic       b_flush, b_pv, b_pr, b_prdy, b_pval, b_af, b_ae;
    logic [7:0] b_pd, b_pdat;
    logic [2:0] b_lvl;

    fifo_sync_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .push_data_i(a_pd), .push_valid_i(a_pv), .push_ready_o(a_prdy),
        .pop_data_o(a_pdat), .pop_valid_o(a_pval), .pop_ready_i(a_pr),
        .level_o(a_lvl), .almost_full_o(a_af), .almost_empty_o(a_ae)
    );

    fifo_sync_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .push_data_i(b_pd), .push_valid_i(b_pv), .push_ready_o(b_prdy),
        .pop_data_o(b_pdat), .pop_valid_o(b_pval), .pop_ready_i(b_pr),
        .level_o(b_lvl), .almost_full_o(b_af), .almost_empty_o(b_ae)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle and the outputs expected during that cycle
    typedef struct {
        int unsigned d;
        string       tag;
        logic        fl;
        logic        pv;
        logic [7:0]  pd;
        logic        pr;
        logic [2:0]  lvl;
        logic        prdy;
        logic        pval;
        logic [7:0]  pdat;
        logic        af;
        logic        ae;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mk(input int unsigned d, input string tag,
                                input logic fl, input logic pv, input logic [7:0] pd,
                                input logic pr, input logic [2:0] lvl, input logic prdy,
                                input logic pval, input logic [7:0] pdat,
                                input logic af, input logic ae);
        vec_t v;
        v.d = d; v.tag = tag; v.fl = fl; v.pv = pv; v.pd = pd; v.pr = pr;
        v.lvl = lvl; v.prdy = prdy; v.pval = pval; v.pdat = pdat; v.af = af; v.ae = ae;
        return v;
    endfunction

    task automatic check(input vec_t v);
        logic [2:0] lvl;
        logic [7:0] dat;
        logic       prdy, pval, af, ae, bad;
        if (v.d == 0) begin
            lvl = a_lvl; dat = a_pdat; prdy = a_prdy; pval = a_pval; af = a_af; ae = a_ae;
        end else begin
            lvl = b_lvl; dat = b_pdat; prdy = b_prdy; pval = b_pval; af = b_af; ae = b_ae;
        end
        bad = (lvl !== v.lvl) || (prdy !== v.prdy) || (pval !== v.pval) ||
              (af !== v.af) || (ae !== v.ae) || (v.pval && dat !== v.pdat);
        nvec++;
        if (bad) begin
            nbad++;
            $display("FAIL vec %0d %s dut%0d: got lvl=%0d rdy=%b val=%b data=%02h af=%b ae=%b, want lvl=%0d rdy=%b val=%b data=%02h af=%b ae=%b",
                     nvec, v.tag, v.d, lvl, prdy, pval, dat, af, ae,
                     v.lvl, v.prdy, v.pval, v.pdat, v.af, v.ae);
        end
    endtask

    task automatic drive(input vec_t v);
        a_flush = 1'b0; a_pv = 1'b0; a_pd = 8'h00; a_pr = 1'b0;
        b_flush = 1'b0; b_pv = 1'b0; b_pd = 8'h00; b_pr = 1'b0;
        if (v.d == 0) begin
            a_flush = v.fl; a_pv = v.pv; a_pd = v.pd; a_pr = v.pr;
        end else begin
            b_flush = v.fl; b_pv = v.pv; b_pd = v.pd; b_pr = v.pr;
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(v);
    endtask

    initial begin
        // A: depth 5 fill past full with backpressure, then drain in order
        tbl.push_back(mk(0, "fill1",   0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, "fill2",   0, 1, 8'h12, 0, 1, 1, 1, 8'h11, 0, 1));
        tbl.push_back(mk(0, "fill3",   0, 1, 8'h13, 0, 2, 1, 1, 8'h11, 0, 0));
        tbl.push_back(mk(0, "fill4",   0, 1, 8'h14, 0, 3, 1, 1, 8'h11, 0, 0));
        tbl.push_back(mk(0, "fill5",   0, 1, 8'h15, 0, 4, 1, 1, 8'h11, 1, 0));
        tbl.push_back(mk(0, "full6",   0, 1, 8'h16, 0, 5, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(0, "drain1",  0, 0, 8'h00, 1, 5, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(0, "drain2",  0, 0, 8'h00, 1, 4, 1, 1, 8'h12, 1, 0));
        tbl.push_back(mk(0, "drain3",  0, 0, 8'h00, 1, 3, 1, 1, 8'h13, 0, 0));
        tbl.push_back(mk(0, "drain4",  0, 0, 8'h00, 1, 2, 1, 1, 8'h14, 0, 0));
        tbl.push_back(mk(0, "drain5",  0, 0, 8'h00, 1, 1, 1, 1, 8'h15, 0, 1));
        tbl.push_back(mk(0, "empty",   0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        // B: prefill 2, then 12 cycles of simultaneous push and pop across wrap
        tbl.push_back(mk(0, "pre1",    0, 1, 8'h20, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, "pre2",    0, 1, 8'h21, 0, 1, 1, 1, 8'h20, 0, 1));
        for (int k = 0; k < 12; k++) begin
            tbl.push_back(mk(0, "stream", 0, 1, 8'(8'h22 + k), 1, 2, 1, 1, 8'(8'h20 + k), 0, 0));
        end
        tbl.push_back(mk(0, "tail1",   0, 0, 8'h00, 1, 2, 1, 1, 8'h2C, 0, 0));
        tbl.push_back(mk(0, "tail2",   0, 0, 8'h00, 1, 1, 1, 1, 8'h2D, 0, 1));
        tbl.push_back(mk(0, "tailE",   0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        // E: push into empty with pop_ready high: no bypass, one-cycle latency
        tbl.push_back(mk(0, "lat0",    0, 1, 8'hA5, 1, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, "lat1",    0, 0, 8'h00, 1, 1, 1, 1, 8'hA5, 0, 1));
        tbl.push_back(mk(0, "lat2",    0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        // C: depth 4 full, push+pop same cycle -> only the pop happens
        tbl.push_back(mk(1, "f4_1",    0, 1, 8'h31, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, "f4_2",    0, 1, 8'h32, 0, 1, 1, 1, 8'h31, 0, 1));
        tbl.push_back(mk(1, "f4_3",    0, 1, 8'h33, 0, 2, 1, 1, 8'h31, 0, 0));
        tbl.push_back(mk(1, "f4_4",    0, 1, 8'h34, 0, 3, 1, 1, 8'h31, 1, 0));
        tbl.push_back(mk(1, "fullpp",  0, 1, 8'h35, 1, 4, 0, 1, 8'h31, 1, 0));
        tbl.push_back(mk(1, "retry",   0, 1, 8'h35, 0, 3, 1, 1, 8'h32, 1, 0));
        tbl.push_back(mk(1, "full2",   0, 0, 8'h00, 0, 4, 0, 1, 8'h32, 1, 0));
        tbl.push_back(mk(1, "d4_1",    0, 0, 8'h00, 1, 4, 0, 1, 8'h32, 1, 0));
        tbl.push_back(mk(1, "d4_2",    0, 0, 8'h00, 1, 3, 1, 1, 8'h33, 1, 0));
        tbl.push_back(mk(1, "d4_3",    0, 0, 8'h00, 1, 2, 1, 1, 8'h34, 0, 0));
        tbl.push_back(mk(1, "d4_4",    0, 0, 8'h00, 1, 1, 1, 1, 8'h35, 0, 1));
        tbl.push_back(mk(1, "d4_E",    0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        // D: flush at level 3 with push and pop requested
        tbl.push_back(mk(1, "fl_p1",   0, 1, 8'h41, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, "fl_p2",   0, 1, 8'h42, 0, 1, 1, 1, 8'h41, 0, 1));
        tbl.push_back(mk(1, "fl_p3",   0, 1, 8'h43, 0, 2, 1, 1, 8'h41, 0, 0));
        tbl.push_back(mk(1, "flush",   1, 1, 8'h44, 1, 3, 1, 1, 8'h41, 1, 0));
        tbl.push_back(mk(1, "postfl",  0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, "fl_new",  0, 1, 8'h45, 0, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, "fl_pop",  0, 0, 8'h00, 1, 1, 1, 1, 8'h45, 0, 1));
        tbl.push_back(mk(1, "fl_E",    0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));

        rst_n = 1'b0;
        drive(mk(0, "idle", 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        #12;
        check(mk(0, "rst5", 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        check(mk(1, "rst4", 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // F: asynchronous reset mid-burst at level 3, then recovery
        apply(mk(0, "rb1",  0, 1, 8'h61, 0, 0, 1, 0, 8'h00, 0, 1));
        apply(mk(0, "rb2",  0, 1, 8'h62, 0, 1, 1, 1, 8'h61, 0, 1));
        apply(mk(0, "rb3",  0, 1, 8'h63, 0, 2, 1, 1, 8'h61, 0, 0));
        apply(mk(0, "rbL3", 0, 0, 8'h00, 0, 3, 1, 1, 8'h61, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        check(mk(0, "async", 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, "rc1",  0, 1, 8'h07, 0, 0, 1, 0, 8'h00, 0, 1));
        apply(mk(0, "rc2",  0, 0, 8'h00, 1, 1, 1, 1, 8'h07, 0, 1));
        apply(mk(0, "rc3",  0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
